// File: rtl/count_reader_pkg.sv
// count_reader_pkg: shared types and constants for the count bus reader.
//   state_e      - reader FSM states
//   NUM_BYTES    - byte positions on the meter bus (fx bytes then fbase bytes)
//   IDX_FX_BASE  - first select index carrying an fx byte
//   IDX_FB_BASE  - first select index carrying an fbase byte
package count_reader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StPassA,
        StPassB,
        StCheck,
        StDone,
        StFail
    } state_e;

    localparam int unsigned NUM_BYTES   = 8;
    localparam int unsigned IDX_FX_BASE = 0;
    localparam int unsigned IDX_FB_BASE = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned SHADOW_W    = NUM_BYTES * BYTE_W;

endpackage

// File: rtl/count_reader_gate_sync.sv
// gate_sync: brings the meter's gate into the sysclk domain and flags its falling edge.
//   sysclk   in  - clock
//   reset    in  - asynchronous, active-high
//   gate     in  - raw gate, asynchronous to sysclk
//   fall_det out - registered one-cycle pulse, 3 cycles after gate goes low
module gate_sync
    import count_reader_pkg::*;
(
    input  logic sysclk,
    input  logic reset,
    input  logic gate,
    output logic fall_det
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       fall_q;
    // Marks which pipeline stages hold a real post-reset sample. The reset-time 1s in the
    // synchronizer must not count as a real "high", or a gate held low through reset release
    // would look like a fall.
    logic [2:0] fill_q;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= gate;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[1:0], 1'b1};
            fall_q  <= fill_q[2] & prev_q & ~sync2_q;
        end
    end

    assign fall_det = fall_q;

endmodule

// File: rtl/count_reader.sv
// count_reader: reads the meter's 8-byte count bus twice after each gate fall and publishes
// the fx/fbase pair only when both passes agree.
//   sysclk, reset       in  - clock, asynchronous active-high reset
//   gate                in  - meter gate (asynchronous)
//   data_in[7:0]        in  - byte selected by {sel0,sel1,sel2}
//   sel0, sel1, sel2    out - byte select code, sel0 is the MSB
//   fx_cnt, fbase_cnt   out - last accepted counts
//   valid               out - one-cycle pulse when the counts update
//   err                 out - one-cycle pulse when all retries mismatched
//   overrun             out - one-cycle pulse for a gate fall seen while not idle
//   busy                out - high from trigger until the DONE/FAIL cycle ends
module count_reader
    import count_reader_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,  // legal 2..255
    parameter int unsigned HOLDOFF_CYCLES = 8,  // legal 1..255
    parameter int unsigned MAX_RETRY      = 3   // legal 0..7
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        gate,
    input  logic [7:0]  data_in,
    output logic        sel0,
    output logic        sel1,
    output logic        sel2,
    output logic [31:0] fx_cnt,
    output logic [31:0] fbase_cnt,
    output logic        valid,
    output logic        err,
    output logic        overrun,
    output logic        busy
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLDOFF_CYCLES - 1);
    localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);
    localparam logic [2:0] IDX_LAST    = 3'(NUM_BYTES - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [2:0]          retry_q, retry_d;
    logic [SHADOW_W-1:0] shad_a_q, shad_a_d;
    logic [SHADOW_W-1:0] shad_b_q, shad_b_d;
    logic [31:0]         fx_q, fx_d;
    logic [31:0]         fb_q, fb_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                ov_q, ov_d;
    logic                busy_q, busy_d;
    logic                fall_det;
    logic                byte_done;

    gate_sync u_gate_sync (
        .sysclk   (sysclk),
        .reset    (reset),
        .gate     (gate),
        .fall_det (fall_det)
    );

    // Last settle cycle of the current select code: data_in is captured here.
    assign byte_done = (cnt_q == SETTLE_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        shad_a_d = shad_a_q;
        shad_b_d = shad_b_q;
        fx_d     = fx_q;
        fb_d     = fb_q;

        unique case (state_q)
            StIdle: begin
                if (fall_det) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            StHold: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = StPassA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StPassA: begin
                if (byte_done) begin
                    shad_a_d[{idx_q, 3'b000} +: 8] = data_in;
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;  // wraps to 0 after the last byte
                    if (idx_q == IDX_LAST) begin
                        state_d = StPassB;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StPassB: begin
                if (byte_done) begin
                    shad_b_d[{idx_q, 3'b000} +: 8] = data_in;
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StCheck;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StCheck: begin
                if (shad_a_q == shad_b_q) begin
                    state_d = StDone;
                    // Load here so the new counts are visible in the same cycle as valid.
                    fx_d    = shad_a_q[IDX_FX_BASE*BYTE_W +: 32];
                    fb_d    = shad_a_q[IDX_FB_BASE*BYTE_W +: 32];
                end else if (retry_q < RETRY_MAX) begin
                    state_d = StPassA;
                    retry_d = retry_q + 3'd1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    state_d = StFail;
                end
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flags are registered from the next state so each lines up with its state cycle.
        valid_d = (state_d == StDone);
        err_d   = (state_d == StFail);
        busy_d  = (state_d != StIdle);
        ov_d    = fall_det && (state_q != StIdle);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            shad_a_q <= '0;
            shad_b_q <= '0;
            fx_q     <= '0;
            fb_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            shad_a_q <= shad_a_d;
            shad_b_q <= shad_b_d;
            fx_q     <= fx_d;
            fb_q     <= fb_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ov_q     <= ov_d;
            busy_q   <= busy_d;
        end
    end

    // idx_q is 0 outside the read passes, so it doubles as the select register.
    assign {sel0, sel1, sel2} = idx_q;
    assign fx_cnt             = fx_q;
    assign fbase_cnt          = fb_q;
    assign valid              = valid_q;
    assign err                = err_q;
    assign overrun            = ov_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_count_reader.sv
module tb_count_reader;

    localparam int S     = 4;
    localparam int H     = 8;
    localparam int MR    = 3;
    localparam int PASS2 = 16 * S;     // both passes of one attempt
    localparam int ATT   = PASS2 + 1;  // attempt length including CHECK

    logic        sysclk = 1'b0;
    logic        reset;
    logic        gate;
    logic [7:0]  data_in;
    logic        sel0, sel1, sel2;
    logic [31:0] fx_cnt, fbase_cnt;
    logic        valid, err, overrun, busy;

    count_reader #(
        .SETTLE_CYCLES  (S),
        .HOLDOFF_CYCLES (H),
        .MAX_RETRY      (MR)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .gate      (gate),
        .data_in   (data_in),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .fx_cnt    (fx_cnt),
        .fbase_cnt (fbase_cnt),
        .valid     (valid),
        .err       (err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_ov    = 0;

    // Next transaction, set by the stimulus while the reader is idle.
    int          next_j  = 0;  // number of attempts whose second pass is corrupted
    logic [31:0] next_fx = '0;
    logic [31:0] next_fb = '0;

    // Reference model state.
    bit          active = 0;
    int          t_trig = 0;
    int          t_j    = 0;
    int          k_att  = 1;
    int          e_end  = 0;
    bit          ok     = 1;
    logic [31:0] t_fx = '0, t_fb = '0;
    logic [3:0]  hist = '0;
    int          nsamp = 0;
    bit          ov_pend = 0;
    logic [31:0] exp_fx = '0, exp_fb = '0;
    bit          exp_valid = 0, exp_err = 0, exp_ov = 0, exp_busy = 0;
    logic [2:0]  exp_sel = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Model: every cycle, derive expected outputs from the trigger time and attempt count.
    initial begin
        int  r, q, a, w;
        bit  fall, idle;
        forever begin
            @(posedge sysclk);
            cyc++;
            if (reset) begin
                hist = '0; nsamp = 0; active = 0; ov_pend = 0;
                exp_fx = '0; exp_fb = '0; exp_valid = 0; exp_err = 0;
                exp_ov = 0; exp_busy = 0; exp_sel = '0;
            end else begin
                hist = {hist[2:0], gate};
                if (nsamp < 4) nsamp++;
                // A fall needs a real high sample followed by a real low sample.
                fall = (nsamp >= 4) && hist[3] && !hist[2];
                r    = cyc - t_trig;
                idle = !(active && r >= 1 && r <= e_end);
                exp_ov  = ov_pend;
                ov_pend = fall && !idle;
                if (fall && idle) begin
                    active = 1; t_trig = cyc; r = 0;
                    t_j = next_j; t_fx = next_fx; t_fb = next_fb;
                    if (t_j <= MR) begin k_att = t_j + 1; ok = 1; end
                    else begin k_att = MR + 1; ok = 0; end
                    e_end = 2 + H + PASS2 + (k_att - 1) * ATT;
                end
                exp_busy = active && r >= 1 && r <= e_end;
                exp_sel  = '0;
                if (exp_busy) begin
                    q = r - (H + 1);
                    if (q >= 0) begin
                        a = q / ATT;
                        w = q % ATT;
                        if (a < k_att && w < PASS2) exp_sel = 3'((w / S) % 8);
                    end
                end
                exp_valid = active && r == e_end && ok;
                exp_err   = active && r == e_end && !ok;
                if (exp_valid) begin exp_fx = t_fx; exp_fb = t_fb; end
            end
            #1;
            if (valid)   n_valid++;
            if (overrun) n_ov++;
            chk("valid",   valid,   exp_valid);
            chk("err",     err,     exp_err);
            chk("overrun", overrun, exp_ov);
            chk("busy",    busy,    exp_busy);
            chk("sel",     {sel0, sel1, sel2}, exp_sel);
            chk("fx_cnt",    fx_cnt,    exp_fx);
            chk("fbase_cnt", fbase_cnt, exp_fb);
        end
    end

    // Meter bus: byte by select code; byte 5 corrupted in the second pass of the first t_j attempts.
    initial begin
        int          br, bq, ba, bw, bi;
        logic [63:0] word;
        logic [7:0]  b;
        data_in = '0;
        forever begin
            @(negedge sysclk);
            bi   = int'({sel0, sel1, sel2});
            word = {t_fb, t_fx};
            b    = word[bi*8 +: 8];
            if (active && bi == 5) begin
                br = cyc - t_trig;
                bq = br - (H + 1);
                if (bq >= 0) begin
                    ba = bq / ATT;
                    bw = bq % ATT;
                    if (ba < t_j && ba < k_att && bw >= 8 * S && bw < PASS2) b = b ^ 8'hA5;
                end
            end
            data_in = b;
        end
    end

    task automatic drop_gate(output int n);
        @(posedge sysclk);
        #2;
        gate = 1'b0;
        n = cyc;
    endtask

    task automatic raise_gate();
        @(posedge sysclk);
        #2;
        gate = 1'b1;
    endtask

    task automatic wait_pulse(input int budget, output int at);
        bit seen;
        seen = 0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge sysclk);
            #2;
            if (valid || err) begin seen = 1; at = cyc; end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_pulse: no valid/err within %0d cycles", budget);
        end
    endtask

    initial begin
        int n, n2, at, v0, o0, kk;
        reset = 1'b1;
        gate  = 1'b1;
        repeat (3) @(negedge sysclk);
        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_sel",   {sel0, sel1, sel2}, 0);
        chk("rst_fx",    fx_cnt, 0);
        chk("rst_fb",    fbase_cnt, 0);
        reset = 1'b0;
        repeat (5) @(posedge sysclk);

        // Static bus.
        next_fx = 32'h12345678; next_fb = 32'h05F5E100; next_j = 0;
        drop_gate(n);
        wait_pulse(400, at);
        chk("lat_static", at - n, 77);
        chk("fx_static",  fx_cnt, 32'h12345678);
        chk("fb_static",  fbase_cnt, 32'h05F5E100);
        chk("err_static", err, 0);

        // One mismatch, one retry.
        raise_gate(); repeat (5) @(posedge sysclk);
        next_j = 1;
        drop_gate(n);
        wait_pulse(400, at);
        chk("lat_retry", at - n, 77 + 65);
        chk("valid_retry", valid, 1);
        chk("fx_retry", fx_cnt, 32'h12345678);

        // Always mismatching: err after four attempts, outputs unchanged.
        raise_gate(); repeat (5) @(posedge sysclk);
        next_j = 4; next_fx = $urandom; next_fb = $urandom;
        drop_gate(n);
        wait_pulse(500, at);
        chk("lat_fail", at - n, 77 + 3 * 65);
        chk("err_fail", err, 1);
        chk("fx_kept",  fx_cnt, 32'h12345678);
        chk("fb_kept",  fbase_cnt, 32'h05F5E100);
        @(posedge sysclk); #2;
        chk("busy_after_fail", busy, 0);

        // Second gate fall during PASS_A.
        raise_gate(); repeat (5) @(posedge sysclk);
        next_j = 0; next_fx = $urandom; next_fb = $urandom;
        v0 = n_valid; o0 = n_ov;
        drop_gate(n);
        repeat (10) @(posedge sysclk);
        raise_gate(); repeat (5) @(posedge sysclk);
        drop_gate(n2);
        wait_pulse(400, at);
        chk("lat_overrun", at - n, 77);
        chk("fx_overrun", fx_cnt, next_fx);
        repeat (300) @(posedge sysclk);
        chk("overrun_count", n_ov - o0, 1);
        chk("valid_count",   n_valid - v0, 1);

        // Reset during PASS_B, gate held low through release.
        raise_gate(); repeat (5) @(posedge sysclk);
        next_fx = $urandom; next_fb = $urandom;
        drop_gate(n);
        repeat (55) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        #1;
        chk("mid_rst_fx",   fx_cnt, 0);
        chk("mid_rst_fb",   fbase_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel",  {sel0, sel1, sel2}, 0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        v0 = n_valid;
        repeat (100) @(posedge sysclk);
        #2;
        chk("no_false_trigger", n_valid - v0, 0);
        chk("idle_after_rst",   busy, 0);
        next_fx = $urandom; next_fb = $urandom; next_j = 0;
        raise_gate(); repeat (5) @(posedge sysclk);
        drop_gate(n);
        wait_pulse(400, at);
        chk("lat_clean", at - n, 77);
        chk("fx_clean",  fx_cnt, next_fx);
        chk("fb_clean",  fbase_cnt, next_fb);

        // Random transactions.
        for (int t = 0; t < 6; t++) begin
            raise_gate();
            repeat ($urandom_range(3, 20)) @(posedge sysclk);
            next_j  = int'($urandom_range(0, 4));
            next_fx = $urandom; next_fb = $urandom;
            drop_gate(n);
            wait_pulse(500, at);
            kk = (next_j <= MR) ? next_j : MR;
            chk("lat_rand",  at - n, 77 + 65 * kk);
            chk("kind_rand", valid, (next_j <= MR) ? 1 : 0);
        end

        repeat (10) @(posedge sysclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
